// File: rtl/fb_rect_writer.sv
// Rectangle fill engine for the 8-bit indexed frame buffer: clips each command to the
// screen, optionally waits for vertical sync, then streams one RAM write per pixel clock.
module fb_rect_writer #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int ADDR_W      = 19,
   parameter int IDX_W       = 8,
   parameter bit WAIT_VBLANK = 1'b1
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              iVS,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [9:0]        cmd_x,
   input  logic [8:0]        cmd_y,
   input  logic [9:0]        cmd_w,
   input  logic [8:0]        cmd_h,
   input  logic [IDX_W-1:0]  cmd_index,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [IDX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              clipped
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT_VS, S_FILL, S_DONE} state_t;

   localparam logic [10:0]       H_L = 11'(H_RES);
   localparam logic [9:0]        V_L = 10'(V_RES);
   localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_RES);

   state_t             state, nxt;
   logic [9:0]         x_q, w_q, col;
   logic [8:0]         y_q, h_q, row;
   logic [IDX_W-1:0]   idx_q;
   logic [ADDR_W-1:0]  row_base;
   logic               vs_d;
   logic               accept, empty, last;
   logic [10:0]        w_room;
   logic [9:0]         h_room;
   logic [9:0]         w_clip;
   logic [8:0]         h_clip;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid & cmd_ready;

   // Geometry is evaluated from the raw latched fields during SETUP only.
   assign empty  = (w_q == 10'd0) | (h_q == 9'd0) | ({1'b0, x_q} >= H_L) | ({1'b0, y_q} >= V_L);
   assign w_room = H_L - {1'b0, x_q};
   assign h_room = V_L - {1'b0, y_q};
   assign w_clip = ({1'b0, w_q} > w_room) ? w_room[9:0] : w_q;
   assign h_clip = ({1'b0, h_q} > h_room) ? h_room[8:0] : h_q;
   assign last   = (col == w_q - 10'd1) & (row == h_q - 9'd1);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) state <= S_IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:    if (accept) nxt = S_SETUP;
         S_SETUP:   nxt = empty ? S_DONE : (WAIT_VBLANK ? S_WAIT_VS : S_FILL);
         S_WAIT_VS: if (vs_d & ~iVS) nxt = S_FILL;
         S_FILL:    if (last) nxt = S_DONE;
         S_DONE:    nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_d     <= 1'b1;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         clipped  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         idx_q    <= '0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
      end else begin
         vs_d  <= iVS;
         wr_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            S_IDLE: if (accept) begin
               x_q   <= cmd_x;
               y_q   <= cmd_y;
               w_q   <= cmd_w;
               h_q   <= cmd_h;
               idx_q <= cmd_index;
            end
            S_SETUP: begin
               // w_q/h_q are reused as the clipped extent from here on.
               if (empty) clipped <= (w_q != 10'd0) & (h_q != 9'd0);
               else       clipped <= (w_clip != w_q) | (h_clip != h_q);
               w_q      <= w_clip;
               h_q      <= h_clip;
               row_base <= ADDR_W'(y_q) * H_A;
               col      <= '0;
               row      <= '0;
            end
            S_FILL: begin
               wr_en   <= 1'b1;
               wr_addr <= row_base + ADDR_W'(x_q) + ADDR_W'(col);
               wr_data <= idx_q;
               if (col == w_q - 10'd1) begin
                  col      <= '0;
                  row      <= row + 9'd1;
                  row_base <= row_base + H_A;
               end else begin
                  col <= col + 10'd1;
               end
            end
            S_DONE: done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: three instances (immediate, vsync-gated, small frame) checked
// every cycle against an arithmetic pixel/timing model, plus hand-computed directed cases.
module tb_fb_rect_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vs = 1'b1;
   logic [2:0]  cv = '0;
   logic [9:0]  cx = '0, cw = '0;
   logic [8:0]  cy = '0, ch = '0;
   logic [7:0]  ci = '0;

   logic [2:0]  we, bz, dn, cl, rdy;
   logic [18:0] wa [3];
   logic [7:0]  wd [3];

   always #5 clk = ~clk;

   // Instance 2 uses a 64x48 frame so the full-frame case fits the cycle budget.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      fb_rect_writer #(
         .H_RES((g == 2) ? 64 : 640), .V_RES((g == 2) ? 48 : 480),
         .ADDR_W(19), .IDX_W(8), .WAIT_VBLANK(g == 1)
      ) u_dut (
         .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
         .cmd_valid(cv[g]), .cmd_ready(rdy[g]),
         .cmd_x(cx), .cmd_y(cy), .cmd_w(cw), .cmd_h(ch), .cmd_index(ci),
         .wr_en(we[g]), .wr_addr(wa[g]), .wr_data(wd[g]),
         .busy(bz[g]), .done(dn[g]), .clipped(cl[g])
      );
   end

   function automatic int hres(int g); return (g == 2) ? 64 : 640; endfunction
   function automatic int vres(int g); return (g == 2) ? 48 : 480; endfunction

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: per command, the edge numbers of write 1..N and of done, plus pixel geometry.
   int mcyc;
   int m_acc [3], m_ed [3], m_n [3], m_x [3], m_y [3], m_wc [3], m_idx [3];
   bit m_act [3], m_clip [3], m_clipn [3], pvs [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcyc = 0;
         for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_clip[i] = 0; m_clipn[i] = 0; m_ed[i] = -1; m_n[i] = 0;
            m_acc[i] = -10; pvs[i] = 1;
         end
      end else begin
         mcyc++;
         for (int i = 0; i < 3; i++) begin
            if (m_act[i]) begin
               if (m_ed[i] < 0 && mcyc >= m_acc[i] + 2 && pvs[i] && !vs) m_ed[i] = mcyc;
               if (mcyc == m_acc[i] + 1) m_clip[i] = m_clipn[i];
               if (m_ed[i] >= 0 && mcyc == m_ed[i] + m_n[i] + 1) m_act[i] = 0;
            end else if (cv[i]) begin
               int x, y, w, h, wc, hc;
               x = int'(cx); y = int'(cy); w = int'(cw); h = int'(ch);
               m_act[i] = 1; m_acc[i] = mcyc; m_x[i] = x; m_y[i] = y; m_idx[i] = int'(ci);
               if (w == 0 || h == 0 || x >= hres(i) || y >= vres(i)) begin
                  m_n[i] = 0; m_clipn[i] = (w > 0 && h > 0); m_ed[i] = mcyc + 1; m_wc[i] = 1;
               end else begin
                  wc = (w < hres(i) - x) ? w : hres(i) - x;
                  hc = (h < vres(i) - y) ? h : vres(i) - y;
                  m_n[i] = wc * hc; m_wc[i] = wc;
                  m_clipn[i] = (wc != w) || (hc != h);
                  m_ed[i] = (i == 1) ? -1 : mcyc + 1;
               end
            end
            pvs[i] = vs;
         end
      end
   end

   int log_a[$], log_d[$], log_e[$];
   int dcnt, dn_e;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            bit ew, ednx;
            logic [4:0] act_v, exp_v;
            ew   = m_ed[i] >= 0 && mcyc >= m_ed[i] + 1 && mcyc <= m_ed[i] + m_n[i];
            ednx = m_ed[i] >= 0 && mcyc == m_ed[i] + m_n[i] + 1;
            act_v = {we[i], bz[i], rdy[i], dn[i], cl[i]};
            exp_v = {ew, m_act[i], !m_act[i], ednx, m_clip[i]};
            chk($sformatf("ctl%0d{wr_en,busy,ready,done,clipped}", i), act_v, exp_v);
            if (ew) begin
               int k, ea;
               k  = mcyc - m_ed[i] - 1;
               ea = (m_y[i] + k / m_wc[i]) * hres(i) + m_x[i] + k % m_wc[i];
               chk($sformatf("addr%0d", i), wa[i], ea);
               chk($sformatf("data%0d", i), wd[i], m_idx[i]);
            end
            if (we[i]) begin log_a.push_back(int'(wa[i])); log_d.push_back(int'(wd[i])); log_e.push_back(mcyc); end
            if (dn[i]) begin dcnt++; dn_e = mcyc; end
         end
      end
   end

   task automatic clr();
      log_a.delete(); log_d.delete(); log_e.delete(); dcnt = 0; dn_e = -1;
   endtask

   task automatic issue(input int g, input int x, input int y, input int w, input int h,
                        input int idx, output int acc);
      @(negedge clk);
      cx = 10'(x); cy = 9'(y); cw = 10'(w); ch = 9'(h); ci = 8'(idx); cv[g] = 1'b1;
      acc = mcyc + 1;
      @(negedge clk);
      cv[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g, input bit rvs);
      int t = 0;
      while (m_act[g] && t < 20000) begin
         @(negedge clk);
         if (rvs) vs = ($urandom_range(0, 2) != 0);
         t++;
      end
      chk($sformatf("timeout%0d", g), m_act[g], 0);
      @(negedge clk);
   endtask

   initial begin
      int acc, c;
      #3;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ctl%0d", i), {we[i], bz[i], rdy[i], dn[i], cl[i]}, 5'b00100);
         chk($sformatf("rst_addr%0d", i), wa[i], 0);
         chk($sformatf("rst_data%0d", i), wd[i], 0);
      end
      #9 rst_n = 1'b1;

      // Small rectangle, immediate start.
      clr(); issue(0, 10, 5, 2, 2, 'h3C, acc); wait_idle(0, 0);
      chk("t1_nwr", log_a.size(), 4);
      if (log_a.size() == 4) begin
         chk("t1_a0", log_a[0], 3210); chk("t1_a1", log_a[1], 3211);
         chk("t1_a2", log_a[2], 3850); chk("t1_a3", log_a[3], 3851);
         chk("t1_d0", log_d[0], 'h3C); chk("t1_lat", log_e[0], acc + 2);
      end
      chk("t1_ndone", dcnt, 1); chk("t1_done_edge", dn_e, acc + 6); chk("t1_clip", cl[0], 0);

      // Bottom-right clip.
      clr(); issue(0, 630, 479, 20, 4, 7, acc); wait_idle(0, 0);
      chk("t2_nwr", log_a.size(), 10);
      if (log_a.size() == 10) begin
         chk("t2_first", log_a[0], 307190); chk("t2_last", log_a[9], 307199);
      end
      chk("t2_ndone", dcnt, 1); chk("t2_clip", cl[0], 1);

      // Empty commands.
      clr(); issue(0, 100, 100, 0, 5, 1, acc); wait_idle(0, 0);
      chk("t3a_nwr", log_a.size(), 0); chk("t3a_done_edge", dn_e, acc + 2); chk("t3a_clip", cl[0], 0);
      clr(); issue(0, 640, 0, 5, 3, 1, acc); wait_idle(0, 0);
      chk("t3b_nwr", log_a.size(), 0); chk("t3b_clip", cl[0], 1);

      // Vsync gating: iVS already low at accept must not start the fill.
      clr(); vs = 1'b0; issue(1, 0, 0, 3, 1, 9, acc);
      repeat (10) @(negedge clk);
      chk("t4_held", log_a.size(), 0); chk("t4_busy", bz[1], 1);
      vs = 1'b1; repeat (3) @(negedge clk);
      vs = 1'b0; c = mcyc;
      wait_idle(1, 0);
      chk("t4_nwr", log_a.size(), 3);
      if (log_a.size() == 3) begin
         chk("t4_start", log_e[0], c + 2); chk("t4_a2", log_a[2], 2);
      end
      vs = 1'b1;

      // Full frame with cmd_valid held high through the fill.
      clr();
      @(negedge clk);
      cx = 0; cy = 0; cw = 10'd64; ch = 9'd48; ci = 8'hA5; cv[2] = 1'b1; acc = mcyc + 1;
      @(negedge clk);
      for (int t = 0; t < 5000 && m_act[2]; t++) @(negedge clk);
      cv[2] = 1'b0;
      @(negedge clk);
      chk("t5_nwr", log_a.size(), 3072); chk("t5_ndone", dcnt, 1); chk("t5_noreacc", bz[2], 0);
      if (log_a.size() == 3072) begin
         chk("t5_first", log_a[0], 0); chk("t5_last", log_a[3071], 3071);
         chk("t5_gapless", log_e[3071] - log_e[0], 3071);
      end

      // Asynchronous reset mid-fill.
      clr(); issue(0, 0, 0, 100, 10, 5, acc);
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("t6_wr_en", we[0], 0); chk("t6_busy", bz[0], 0);
      #1 rst_n = 1'b1;
      @(negedge clk); chk("t6_ready", rdy[0], 1);
      clr(); issue(0, 1, 1, 3, 1, 'h55, acc); wait_idle(0, 0);
      chk("t6_nwr", log_a.size(), 3);
      if (log_a.size() == 3) begin chk("t6_a0", log_a[0], 641); chk("t6_a2", log_a[2], 643); end

      // Randomized commands, biased toward the right/bottom edges.
      for (int r = 0; r < 60; r++) begin
         int g, x, y, w, h;
         g = r % 3;
         x = ($urandom_range(0, 3) == 0) ? $urandom_range(hres(g) - 12, hres(g) + 3)
                                         : $urandom_range(0, hres(g) - 1);
         y = ($urandom_range(0, 3) == 0) ? $urandom_range(vres(g) - 6, vres(g) + 3)
                                         : $urandom_range(0, vres(g) - 1);
         w = $urandom_range(0, 14);
         h = $urandom_range(0, 6);
         issue(g, x, y, w, h, $urandom_range(0, 255), acc);
         wait_idle(g, g == 1);
         vs = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
